// File: rtl/gray_conv.sv
// gray_conv: RGB-to-luma source stage. Converts a raster-order RGB stream to
// In_Width-bit gray, stores one full frame, then opens a 1-cycle-latency
// random-access read port for the downstream filter.
module gray_conv #(
  parameter int In_Width   = 8,
  parameter int Addr_Width = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rgb_valid,
  input  logic [3*In_Width-1:0] rgb_data,
  output logic                  rgb_ready,
  output logic                  gray_ready,
  input  logic                  gray_req,
  input  logic [Addr_Width-1:0] gray_addr,
  output logic [In_Width-1:0]   gray_data
);

  // Weighted sum needs 8 bits of headroom above the channel width:
  // (77+150+29) = 256 times the max channel value, plus the rounding 128.
  localparam int Pw = In_Width + 8;
  localparam int Depth = 2 ** Addr_Width;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    DRAIN = 2'd1,
    READY = 2'd2
  } state_t;

  state_t                state;
  logic [Addr_Width-1:0] wr_addr;
  logic                  accept;

  // Conversion pipeline stage 1 registers.
  logic                  p_valid;
  logic [Addr_Width-1:0] p_addr;
  logic [Pw-1:0]         p_r;
  logic [Pw-1:0]         p_g;
  logic [Pw-1:0]         p_b;
  logic [Pw-1:0]         sum;

  logic [In_Width-1:0]   mem [Depth];

  logic [In_Width-1:0]   ch_r;
  logic [In_Width-1:0]   ch_g;
  logic [In_Width-1:0]   ch_b;

  assign ch_r   = rgb_data[3*In_Width-1:2*In_Width];
  assign ch_g   = rgb_data[2*In_Width-1:In_Width];
  assign ch_b   = rgb_data[In_Width-1:0];
  assign accept = rgb_valid & rgb_ready;
  assign sum    = p_r + p_g + p_b + Pw'(128);

  // Frame-load FSM: write pointer, handshake and frame-complete flags.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LOAD;
      wr_addr    <= '0;
      rgb_ready  <= 1'b1;
      gray_ready <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            wr_addr <= wr_addr + Addr_Width'(1);
            if (wr_addr == '1) begin
              state     <= DRAIN;
              rgb_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // The last pixel is in the pipeline; this edge commits it.
          if (p_valid) begin
            state      <= READY;
            gray_ready <= 1'b1;
          end
        end
        READY: begin
          state      <= READY;
          gray_ready <= 1'b1;
        end
        default: begin
          state     <= LOAD;
          rgb_ready <= 1'b1;
        end
      endcase
    end
  end

  // Stage 1: register the three weighted channel products and the target address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_valid <= 1'b0;
      p_addr  <= '0;
      p_r     <= '0;
      p_g     <= '0;
      p_b     <= '0;
    end else begin
      p_valid <= accept;
      if (accept) begin
        p_addr <= wr_addr;
        p_r    <= Pw'(ch_r) * Pw'(77);
        p_g    <= Pw'(ch_g) * Pw'(150);
        p_b    <= Pw'(ch_b) * Pw'(29);
      end
    end
  end

  // Stage 2: round, scale and commit the luma sample to the frame memory.
  // NOTE: the frame memory has no reset; it is always fully rewritten before
  // the read port opens, and a reset would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (p_valid) begin
      mem[p_addr] <= In_Width'(sum >> 8);
    end
  end

  // Read port: one registered word per request, held while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gray_data <= '0;
    end else if (gray_req && state == READY) begin
      gray_data <= mem[gray_addr];
    end
  end

endmodule

// File: tb/tb_gray_conv.sv
// tb_gray_conv: self-checking bench for gray_conv on a reduced 1024-pixel frame.
// A reference array of expected gray samples is built from the luma formula
// as pixels are handed over, then compared against reads of the DUT.
module tb_gray_conv;

  localparam int Aw = 10;
  localparam int N  = 2 ** Aw;

  logic          clk = 1'b0;
  logic          rst;
  logic          rgb_valid;
  logic [23:0]   rgb_data;
  logic          rgb_ready;
  logic          gray_ready;
  logic          gray_req;
  logic [Aw-1:0] gray_addr;
  logic [7:0]    gray_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [7:0] exp_mem [N];
  int         m_cnt;
  logic       m_gray_exp;

  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] y;
  } vec_t;

  vec_t vecs [4];

  gray_conv #(
    .In_Width  (8),
    .Addr_Width(Aw)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rgb_valid (rgb_valid),
    .rgb_data  (rgb_data),
    .rgb_ready (rgb_ready),
    .gray_ready(gray_ready),
    .gray_req  (gray_req),
    .gray_addr (gray_addr),
    .gray_data (gray_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] luma(input logic [23:0] d);
    int s;
    s = 77 * int'(d[23:16]) + 150 * int'(d[15:8]) + 29 * int'(d[7:0]) + 128;
    return 8'(s / 256);
  endfunction

  function automatic logic [23:0] golden_pix(input int n);
    logic [15:0] nn;
    nn = 16'(n);
    return {nn[7:0], nn[15:8], nn[7:0] ^ nn[15:8]};
  endfunction

  // Apply one input cycle: check handshake flags, update model, clock.
  task automatic cycle(input logic v, input logic [23:0] d);
    logic full_before;
    rgb_valid = v;
    rgb_data  = d;
    check("rgb_ready", 32'(rgb_ready), 32'(m_cnt < N));
    check("gray_ready", 32'(gray_ready), 32'(m_gray_exp));
    full_before = (m_cnt == N);
    if (v && m_cnt < N) begin
      exp_mem[m_cnt] = luma(d);
      m_cnt++;
    end
    @(posedge clk);
    #1;
    m_gray_exp = full_before;
    rgb_valid  = 1'b0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    rgb_valid = 1'b0;
    gray_req  = 1'b0;
    @(posedge clk);
    #1;
    check("rst_rgb_ready", 32'(rgb_ready), 32'd1);
    check("rst_gray_ready", 32'(gray_ready), 32'd0);
    check("rst_gray_data", 32'(gray_data), 32'd0);
    rst = 1'b0;
    m_cnt      = 0;
    m_gray_exp = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Complete the current frame with random pixels and ~30% idle cycles.
  task automatic fill_random();
    while (m_cnt < N) begin
      cycle($urandom_range(99) >= 30, 24'($urandom));
    end
  endtask

  task automatic read_one(input int a);
    gray_req  = 1'b1;
    gray_addr = Aw'(a);
    @(posedge clk);
    #1;
    gray_req = 1'b0;
    check("read_data", 32'(gray_data), 32'(exp_mem[a]));
  endtask

  task automatic read_all();
    for (int a = 0; a < N; a++) begin
      read_one(a);
    end
  endtask

  initial begin
    logic [7:0] held;
    int         a;

    vecs[0] = '{8'd255, 8'd0,   8'd0,   8'd77};
    vecs[1] = '{8'd0,   8'd255, 8'd0,   8'd149};
    vecs[2] = '{8'd0,   8'd0,   8'd255, 8'd29};
    vecs[3] = '{8'd255, 8'd255, 8'd255, 8'd255};

    rst        = 1'b1;
    rgb_valid  = 1'b0;
    rgb_data   = '0;
    gray_req   = 1'b0;
    gray_addr  = '0;
    m_cnt      = 0;
    m_gray_exp = 1'b0;
    #12;
    do_reset();

    // Idle after reset; read requests are ignored before the frame is ready.
    for (int i = 0; i < 10; i++) begin
      gray_req  = 1'b1;
      gray_addr = Aw'($urandom);
      cycle(1'b0, '0);
      check("idle_gray_data", 32'(gray_data), 32'd0);
    end
    gray_req = 1'b0;

    // Frame A: table vectors at addresses 0..3, then random pixels with gaps.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, {vecs[i].r, vecs[i].g, vecs[i].b});
    end
    fill_random();
    // Valid pixels after the frame is complete must be ignored.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 24'hFFFFFF);
    end
    for (int i = 0; i < 4; i++) begin
      read_one(i);
      check("table_luma", 32'(gray_data), 32'(vecs[i].y));
    end
    read_all();
    for (int i = 0; i < 200; i++) begin
      read_one(int'($urandom_range(N - 1)));
    end

    // Back-to-back reads at three addresses, then hold with req low.
    gray_req = 1'b1;
    gray_addr = Aw'(12'h100);
    @(posedge clk); #1;
    check("b2b_0", 32'(gray_data), 32'(exp_mem[12'h100]));
    gray_addr = Aw'(12'h1FF);
    @(posedge clk); #1;
    check("b2b_1", 32'(gray_data), 32'(exp_mem[12'h1FF]));
    gray_addr = '1;
    @(posedge clk); #1;
    check("b2b_2", 32'(gray_data), 32'(exp_mem[N - 1]));
    gray_req = 1'b0;
    held = exp_mem[N - 1];
    for (int i = 0; i < 5; i++) begin
      gray_addr = Aw'(i);
      @(posedge clk); #1;
      check("hold_data", 32'(gray_data), 32'(held));
    end

    // Frame B: golden pattern, no gaps; exact gray_ready timing via cycle().
    do_reset();
    for (int n = 0; n < N; n++) begin
      cycle(1'b1, golden_pix(n));
    end
    cycle(1'b0, '0);
    cycle(1'b0, '0);
    for (int n = 0; n < N; n++) begin
      check("golden_model", 32'(exp_mem[n]), 32'(luma(golden_pix(n))));
    end
    read_all();

    // Frame C: abandon after 1000 pixels, then a fresh random frame.
    do_reset();
    while (m_cnt < 1000) begin
      cycle($urandom_range(99) >= 30, 24'($urandom));
    end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0);
    end
    fill_random();
    cycle(1'b0, '0);
    a = 0;
    read_one(a);
    read_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
